// File: rtl/ll_pkg.sv
// rtl/ll_pkg.sv - shared constants and width helpers for the ll_engine slice
// Purpose: default parameter values, clog2 helper and the derived width
//          functions used by ll_engine and ll_win_ring.
// Ports:   none (package).
package ll_pkg;

  localparam int DEF_IN_W    = 16;
  localparam int DEF_WIN_LEN = 50;
  localparam int DEF_NUM_WIN = 5;
  localparam int DEF_NUM_CH  = 4;

  // Smallest r with 2**r >= v (clog2(1) == 0).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int at_least_1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int ch_w(input int num_ch);
    return at_least_1(clog2(num_ch));
  endfunction

  // One window sum: WIN_LEN deltas of IN_W+1 bits each.
  function automatic int mid_w(input int in_w, input int win_len);
    return in_w + 1 + clog2(win_len);
  endfunction

  // Running total of NUM_WIN window sums.
  function automatic int out_w(input int in_w, input int win_len, input int num_win);
    return mid_w(in_w, win_len) + clog2(num_win);
  endfunction

endpackage

// File: rtl/ll_win_ring.sv
// rtl/ll_win_ring.sv - per-channel ring of window sums with running total
// Purpose: holds NUM_WIN window sums per channel, the oldest-slot pointer and
//          the running total; total_next is the total after replacing the
//          oldest slot of channel ch with wsum, committed when wr_en is high.
// Ports:   clk, rst_n (async active-low), clr (sync clear),
//          wr_en (commit wsum for ch), ch (channel index), wsum (closed
//          window sum), total_next (combinational updated total for ch).
module ll_win_ring
  import ll_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int NUM_WIN = DEF_NUM_WIN,
  parameter int CH_W    = 2,
  parameter int MID_W   = 23,
  parameter int OUT_W   = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  ch,
  input  logic [MID_W-1:0] wsum,
  output logic [OUT_W-1:0] total_next
);

  localparam int PTR_W = at_least_1(clog2(NUM_WIN));

  logic [MID_W-1:0] ring  [NUM_CH][NUM_WIN];
  logic [PTR_W-1:0] ptr   [NUM_CH];
  logic [OUT_W-1:0] total [NUM_CH];
  logic [MID_W-1:0] oldest;

  // total always equals the sum of the ring, so the subtraction cannot underflow.
  assign oldest     = ring[ch][ptr[ch]];
  assign total_next = total[ch] + OUT_W'(wsum) - OUT_W'(oldest);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ptr[c]   <= '0;
        total[c] <= '0;
        for (int w = 0; w < NUM_WIN; w++) ring[c][w] <= '0;
      end
    end else if (clr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ptr[c]   <= '0;
        total[c] <= '0;
        for (int w = 0; w < NUM_WIN; w++) ring[c][w] <= '0;
      end
    end else if (wr_en) begin
      ring[ch][ptr[ch]] <= wsum;
      total[ch]         <= total_next;
      ptr[ch]           <= (ptr[ch] == PTR_W'(NUM_WIN - 1)) ? '0 : ptr[ch] + PTR_W'(1);
    end
  end

endmodule

// File: rtl/ll_engine.sv
// rtl/ll_engine.sv - multi-channel windowed line-length engine
// Purpose: per channel, sums |x - prev| over windows of WIN_LEN samples and
//          emits the sum of the last NUM_WIN windows at every window close.
//          Optional macro LL_WARMUP_EN suppresses results until a channel has
//          completed NUM_WIN windows.
// Ports:   clk, rst_n (async active-low), clr (sync clear of all channels),
//          in_valid/in_ready/in_ch/in_data (sample input),
//          out_valid/out_ready/out_ch/out_data (result output, latency 1).
module ll_engine
  import ll_pkg::*;
#(
  parameter  int IN_W    = DEF_IN_W,
  parameter  int WIN_LEN = DEF_WIN_LEN,
  parameter  int NUM_WIN = DEF_NUM_WIN,
  parameter  int NUM_CH  = DEF_NUM_CH,
  localparam int CH_W    = ch_w(NUM_CH),
  localparam int MID_W   = mid_w(IN_W, WIN_LEN),
  localparam int OUT_W   = out_w(IN_W, WIN_LEN, NUM_WIN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [CH_W-1:0]        in_ch,
  input  logic signed [IN_W-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH_W-1:0]        out_ch,
  output logic [OUT_W-1:0]       out_data
);

  localparam int CNT_W = at_least_1(clog2(WIN_LEN));
  localparam int D_W   = IN_W + 1;
  localparam logic [CH_W:0] CH_LIMIT = NUM_CH[CH_W:0];

  logic signed [IN_W-1:0] prev [NUM_CH];
  logic                   seen [NUM_CH];
  logic [CNT_W-1:0]       cnt  [NUM_CH];
  logic [MID_W-1:0]       acc  [NUM_CH];
`ifdef LL_WARMUP_EN
  localparam int WC_W = at_least_1(clog2(NUM_WIN + 1));
  logic [WC_W-1:0]        wcnt [NUM_CH];
`endif

  logic                  ch_ok;
  logic                  accept;
  logic                  closing;
  logic                  emit;
  logic signed [D_W-1:0] diff;
  logic [D_W-1:0]        d;
  logic [MID_W-1:0]      wsum;
  logic [OUT_W-1:0]      total_next;

  // A close only happens on an accepted sample, and acceptance requires the
  // output register to be free or draining this cycle.
  assign in_ready = rst_n && !clr && (!out_valid || out_ready);

  // Out-of-range channels are handshaken but leave no trace.
  assign ch_ok  = {1'b0, in_ch} < CH_LIMIT;
  assign accept = in_valid && in_ready && ch_ok;

  assign diff    = $signed({in_data[IN_W-1], in_data}) - $signed({prev[in_ch][IN_W-1], prev[in_ch]});
  assign d       = !seen[in_ch] ? '0 : (diff[D_W-1] ? D_W'(-diff) : D_W'(diff));
  assign closing = (cnt[in_ch] == CNT_W'(WIN_LEN - 1));
  assign wsum    = acc[in_ch] + MID_W'(d);

`ifdef LL_WARMUP_EN
  // This close brings (or keeps) the completed-window count at NUM_WIN.
  assign emit = (wcnt[in_ch] == WC_W'(NUM_WIN)) || (wcnt[in_ch] == WC_W'(NUM_WIN - 1));
`else
  assign emit = 1'b1;
`endif

  ll_win_ring #(
    .NUM_CH  (NUM_CH),
    .NUM_WIN (NUM_WIN),
    .CH_W    (CH_W),
    .MID_W   (MID_W),
    .OUT_W   (OUT_W)
  ) u_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .wr_en      (accept && closing),
    .ch         (in_ch),
    .wsum       (wsum),
    .total_next (total_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        prev[c] <= '0;
        seen[c] <= 1'b0;
        cnt[c]  <= '0;
        acc[c]  <= '0;
`ifdef LL_WARMUP_EN
        wcnt[c] <= '0;
`endif
      end
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else if (clr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        prev[c] <= '0;
        seen[c] <= 1'b0;
        cnt[c]  <= '0;
        acc[c]  <= '0;
`ifdef LL_WARMUP_EN
        wcnt[c] <= '0;
`endif
      end
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        prev[in_ch] <= in_data;
        seen[in_ch] <= 1'b1;
        if (closing) begin
          cnt[in_ch] <= '0;
          acc[in_ch] <= '0;
`ifdef LL_WARMUP_EN
          if (wcnt[in_ch] != WC_W'(NUM_WIN)) wcnt[in_ch] <= wcnt[in_ch] + WC_W'(1);
`endif
          if (emit) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_data  <= total_next;
          end
        end else begin
          cnt[in_ch] <= cnt[in_ch] + CNT_W'(1);
          acc[in_ch] <= wsum;
        end
      end
    end
  end

endmodule

// File: tb/tb_ll_engine.sv
// tb/tb_ll_engine.sv - self-checking bench for ll_engine (WIN_LEN=4, NUM_WIN=2, NUM_CH=2)
module tb_ll_engine;

  localparam int IN_W    = 16;
  localparam int WIN_LEN = 4;
  localparam int NUM_WIN = 2;
  localparam int NUM_CH  = 2;
  localparam int OUT_W   = 20;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   clr = 1'b0;
  logic                   in_valid = 1'b0;
  logic [0:0]             in_ch = 1'b0;
  logic signed [IN_W-1:0] in_data = '0;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [0:0]             out_ch;
  logic [OUT_W-1:0]       out_data;

  ll_engine #(
    .IN_W    (IN_W),
    .WIN_LEN (WIN_LEN),
    .NUM_WIN (NUM_WIN),
    .NUM_CH  (NUM_CH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: per channel, last sample, partial window, list of closed window sums.
  int m_prev [NUM_CH];
  bit m_seen [NUM_CH];
  int m_cnt  [NUM_CH];
  int m_acc  [NUM_CH];
  int m_wins [NUM_CH][$];
`ifdef LL_WARMUP_EN
  int m_done [NUM_CH];
`endif
  int exp_ch[$];
  int exp_data[$];
  int obs_ch[$];
  int obs_data[$];

  function automatic void check(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_prev[c] = 0;
      m_seen[c] = 1'b0;
      m_cnt[c]  = 0;
      m_acc[c]  = 0;
      m_wins[c].delete();
`ifdef LL_WARMUP_EN
      m_done[c] = 0;
`endif
    end
    exp_ch.delete();
    exp_data.delete();
  endfunction

  // Result = sum of the last NUM_WIN window sums of |x - previous x|.
  function automatic void model_accept(int c, int x);
    int d;
    int tot;
    d = !m_seen[c] ? 0 : ((x > m_prev[c]) ? x - m_prev[c] : m_prev[c] - x);
    m_seen[c] = 1'b1;
    m_prev[c] = x;
    m_acc[c] += d;
    m_cnt[c]++;
    if (m_cnt[c] == WIN_LEN) begin
      m_wins[c].push_back(m_acc[c]);
      if (m_wins[c].size() > NUM_WIN) void'(m_wins[c].pop_front());
      tot = 0;
      for (int i = 0; i < m_wins[c].size(); i++) tot += m_wins[c][i];
      m_acc[c] = 0;
      m_cnt[c] = 0;
`ifdef LL_WARMUP_EN
      m_done[c]++;
      if (m_done[c] >= NUM_WIN) begin
        exp_ch.push_back(c);
        exp_data.push_back(tot);
      end
`else
      exp_ch.push_back(c);
      exp_data.push_back(tot);
`endif
    end
  endfunction

  // Compare process: every consumed result must match the model, in order.
  int e_c;
  int e_d;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      obs_ch.push_back(int'(out_ch));
      obs_data.push_back(int'(out_data));
      if (exp_data.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_result: got ch %0d data %0d, expected no result", out_ch, out_data);
      end else begin
        e_c = exp_ch.pop_front();
        e_d = exp_data.pop_front();
        check("out_ch", int'(out_ch), e_c);
        check("out_data", int'(out_data), e_d);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the sample is accepted.
  task automatic send(int c, int x);
    int n;
    in_valid = 1'b1;
    in_ch    = c[0:0];
    in_data  = x[IN_W-1:0];
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready got 0 for 50 cycles, expected 1");
    end else begin
      model_accept(c, x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Clear with a concurrent sample offered: the sample must be refused.
  task automatic do_clr();
    clr      = 1'b1;
    in_valid = 1'b1;
    in_ch    = 1'b0;
    in_data  = 16'sd1234;
    @(negedge clk);
    check("in_ready_during_clr", int'(in_ready), 0);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    model_clear();
    @(negedge clk);
    check("out_valid_after_clr", int'(out_valid), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic check_obs(string name, int idx, int want);
    if (idx < obs_data.size()) check(name, obs_data[idx], want);
    else check({name, "_missing"}, -1, want);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    #12;
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_ch", int'(out_ch), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp step 10 on ch0.
    obs_data.delete(); obs_ch.delete();
    for (int i = 0; i < 12; i++) send(0, i * 10);
    drain();
`ifdef LL_WARMUP_EN
    check("ramp_count", obs_data.size(), 2);
    check_obs("ramp_first", 0, 70);
    check_obs("ramp_second", 1, 80);
`else
    check("ramp_count", obs_data.size(), 3);
    check_obs("ramp_first", 0, 30);
    check_obs("ramp_second", 1, 70);
    check_obs("ramp_third", 2, 80);
`endif

    // Full-scale alternation.
    do_clr();
    obs_data.delete(); obs_ch.delete();
    for (int i = 0; i < 12; i++) send(0, (i % 2 == 0) ? 32767 : -32768);
    drain();
`ifdef LL_WARMUP_EN
    check("fs_count", obs_data.size(), 2);
    check_obs("fs_first", 0, 458745);
    check_obs("fs_second", 1, 524280);
`else
    check("fs_count", obs_data.size(), 3);
    check_obs("fs_first", 0, 196605);
    check_obs("fs_second", 1, 458745);
    check_obs("fs_third", 2, 524280);
`endif

    // Interleaved ch0 ramp and ch1 constant.
    do_clr();
    obs_data.delete(); obs_ch.delete();
    for (int i = 0; i < 12; i++) begin
      send(0, i * 10);
      send(1, 5);
    end
    drain();
`ifdef LL_WARMUP_EN
    check("ilv_count", obs_data.size(), 4);
    check_obs("ilv_ch0_first", 0, 70);
    check_obs("ilv_ch1_first", 1, 0);
    check_obs("ilv_ch0_second", 2, 80);
`else
    check("ilv_count", obs_data.size(), 6);
    check_obs("ilv_ch0_first", 0, 30);
    check_obs("ilv_ch1_first", 1, 0);
    check_obs("ilv_ch0_third", 4, 80);
`endif

    // Backpressure: hold the 70 result while a new sample is offered.
    do_clr();
    obs_data.delete(); obs_ch.delete();
    for (int i = 0; i < 7; i++) send(0, i * 10);
    drain();
    out_ready = 1'b0;
    send(0, 70);
    fork
      send(0, 80);
      begin
        repeat (4) begin
          @(negedge clk);
          check("bp_in_ready", int'(in_ready), 0);
          check("bp_out_valid", int'(out_valid), 1);
          check("bp_held_data", int'(out_data), 70);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    send(0, 90);
    send(0, 100);
    send(0, 110);
    drain();
`ifdef LL_WARMUP_EN
    check("bp_count", obs_data.size(), 2);
    check_obs("bp_first", 0, 70);
    check_obs("bp_second", 1, 80);
`else
    check("bp_count", obs_data.size(), 3);
    check_obs("bp_second", 1, 70);
    check_obs("bp_third", 2, 80);
`endif

    // Clear mid-window, then restart the ramp.
    do_clr();
    for (int i = 0; i < 6; i++) send(0, i * 10);
    drain();
    do_clr();
    obs_data.delete(); obs_ch.delete();
    for (int i = 0; i < 8; i++) send(0, i * 10);
    drain();
`ifdef LL_WARMUP_EN
    check("clr_mid_count", obs_data.size(), 1);
    check_obs("clr_mid_first", 0, 70);
`else
    check("clr_mid_count", obs_data.size(), 2);
    check_obs("clr_mid_first", 0, 30);
    check_obs("clr_mid_second", 1, 70);
`endif

    // Reset pulse mid-window, then restart the ramp.
    do_clr();
    for (int i = 0; i < 6; i++) send(0, i * 10);
    drain();
    rst_n = 1'b0;
    #2;
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_in_ready", int'(in_ready), 0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    obs_data.delete(); obs_ch.delete();
    for (int i = 0; i < 8; i++) send(0, i * 10);
    drain();
`ifdef LL_WARMUP_EN
    check("rst_mid_count", obs_data.size(), 1);
    check_obs("rst_mid_first", 0, 70);
`else
    check("rst_mid_count", obs_data.size(), 2);
    check_obs("rst_mid_first", 0, 30);
    check_obs("rst_mid_second", 1, 70);
`endif

    check("scoreboard_empty", exp_data.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
